// File: rtl/cardjitsu_input_cond_if.sv
// Signal bundle between the raw front-panel inputs and the Card-Jitsu game controller.
// The slave side is the conditioning block; the master side drives the raw inputs.
interface cardjitsu_input_cond_if;
  logic       btn_0_raw;
  logic       btn_1_raw;
  logic       btn_2_raw;
  logic [3:0] sw_raw;
  logic       btn_0;
  logic       btn_1;
  logic       btn_2;
  logic       btn_0_pulse;
  logic       btn_1_pulse;
  logic       btn_2_pulse;
  logic [3:0] sw;
  logic [3:0] sw_cap;

  modport master (
    output btn_0_raw, btn_1_raw, btn_2_raw, sw_raw,
    input  btn_0, btn_1, btn_2, btn_0_pulse, btn_1_pulse, btn_2_pulse, sw, sw_cap
  );

  modport slave (
    input  btn_0_raw, btn_1_raw, btn_2_raw, sw_raw,
    output btn_0, btn_1, btn_2, btn_0_pulse, btn_1_pulse, btn_2_pulse, sw, sw_cap
  );
endinterface

// File: rtl/cardjitsu_input_cond.sv
// Synchronises and debounces the three game buttons and the 4-bit card switch bus,
// emitting press pulses and a card value latched on every btn_0 press.
module cardjitsu_input_cond #(
  parameter int DB_CYCLES = 20000,
  parameter int CNT_W     = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  cardjitsu_input_cond_if.slave  io
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [2:0]            btn_raw;
  logic [2:0]            btn_s1;
  logic [2:0]            btn_s2;
  logic [2:0]            btn_stable;
  logic [2:0]            btn_stable_nxt;
  logic [2:0]            btn_pulse;
  logic [2:0][CNT_W-1:0] btn_cnt;
  logic [2:0][CNT_W-1:0] btn_cnt_nxt;

  logic [3:0]            sw_s1;
  logic [3:0]            sw_s2;
  logic [3:0]            sw_cand;
  logic [3:0]            sw_q;
  logic [3:0]            sw_cap_q;
  logic [CNT_W-1:0]      sw_cnt;
  logic [3:0]            sw_cand_nxt;
  logic [3:0]            sw_q_nxt;
  logic [CNT_W-1:0]      sw_cnt_nxt;
  logic                  btn_0_press;

  assign btn_raw = {io.btn_2_raw, io.btn_1_raw, io.btn_0_raw};

  // Per-button debounce: a change is accepted only after DB_CYCLES disagreeing samples
  always_comb begin
    btn_stable_nxt = btn_stable;
    btn_cnt_nxt    = btn_cnt;
    for (int i = 0; i < 3; i++) begin
      if (btn_s2[i] == btn_stable[i]) begin
        btn_cnt_nxt[i] = '0;
      end else if (btn_cnt[i] == CNT_MAX) begin
        btn_stable_nxt[i] = btn_s2[i];
        btn_cnt_nxt[i]    = '0;
      end else begin
        btn_cnt_nxt[i] = btn_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Whole-bus switch debounce: any bit change restarts the count on the new candidate
  always_comb begin
    sw_cand_nxt = sw_cand;
    sw_q_nxt    = sw_q;
    sw_cnt_nxt  = sw_cnt;
    if (sw_s2 != sw_cand) begin
      sw_cand_nxt = sw_s2;
      sw_cnt_nxt  = '0;
    end else if (sw_cand != sw_q) begin
      if (sw_cnt == CNT_MAX) begin
        sw_q_nxt   = sw_cand;
        sw_cnt_nxt = '0;
      end else begin
        sw_cnt_nxt = sw_cnt + CNT_W'(1);
      end
    end else begin
      sw_cnt_nxt = '0;
    end
  end

  assign btn_0_press = btn_stable_nxt[0] & ~btn_stable[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1     <= '0;
      btn_s2     <= '0;
      btn_stable <= '0;
      btn_pulse  <= '0;
      btn_cnt    <= '0;
      sw_s1      <= '0;
      sw_s2      <= '0;
      sw_cand    <= '0;
      sw_q       <= '0;
      sw_cnt     <= '0;
      sw_cap_q   <= '0;
    end else begin
      btn_s1     <= btn_raw;
      btn_s2     <= btn_s1;
      btn_stable <= btn_stable_nxt;
      btn_pulse  <= btn_stable_nxt & ~btn_stable;
      btn_cnt    <= btn_cnt_nxt;
      sw_s1      <= io.sw_raw;
      sw_s2      <= sw_s1;
      sw_cand    <= sw_cand_nxt;
      sw_q       <= sw_q_nxt;
      sw_cnt     <= sw_cnt_nxt;
      // Capture the pre-edge debounced card so a same-edge sw update is not seen
      if (btn_0_press) sw_cap_q <= sw_q;
    end
  end

  assign io.btn_0       = btn_stable[0];
  assign io.btn_1       = btn_stable[1];
  assign io.btn_2       = btn_stable[2];
  assign io.btn_0_pulse = btn_pulse[0];
  assign io.btn_1_pulse = btn_pulse[1];
  assign io.btn_2_pulse = btn_pulse[2];
  assign io.sw          = sw_q;
  assign io.sw_cap      = sw_cap_q;

endmodule

// File: tb/tb_cardjitsu_input_cond.sv
// Directed bench for cardjitsu_input_cond with DB_CYCLES=4: per-cycle vector table
// plus hand sequences for switch bounce and a reset landing mid-debounce.
module tb_cardjitsu_input_cond;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  cardjitsu_input_cond_if io ();

  cardjitsu_input_cond #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] b;
    logic [3:0] swr;
    logic [2:0] eb;
    logic [2:0] ep;
    logic [3:0] esw;
    logic [3:0] ecap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] b, input logic [3:0] swr,
                     input logic [2:0] eb, input logic [2:0] ep,
                     input logic [3:0] esw, input logic [3:0] ecap, input int n);
    vec_t v;
    v.rst = r; v.b = b; v.swr = swr; v.eb = eb; v.ep = ep; v.esw = esw; v.ecap = ecap;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [2:0] b, input logic [3:0] swr);
    rst          = r;
    io.btn_0_raw = b[0];
    io.btn_1_raw = b[1];
    io.btn_2_raw = b[2];
    io.sw_raw    = swr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] btns();
    return {1'b0, io.btn_2, io.btn_1, io.btn_0};
  endfunction

  function automatic logic [3:0] pulses();
    return {1'b0, io.btn_2_pulse, io.btn_1_pulse, io.btn_0_pulse};
  endfunction

  initial begin
    drive(1'b1, 3'b000, 4'h0);

    // reset with raw inputs high, then clean btn_0 press and a btn_1 glitch
    add(1, 3'b111, 4'hF, 3'b000, 3'b000, 4'd0, 4'd0, 3);
    add(0, 3'b000, 4'h0, 3'b000, 3'b000, 4'd0, 4'd0, 1);
    add(0, 3'b001, 4'h0, 3'b000, 3'b000, 4'd0, 4'd0, 5);
    add(0, 3'b001, 4'h0, 3'b001, 3'b001, 4'd0, 4'd0, 1);
    add(0, 3'b001, 4'h0, 3'b001, 3'b000, 4'd0, 4'd0, 1);
    add(0, 3'b011, 4'h0, 3'b001, 3'b000, 4'd0, 4'd0, 3);
    add(0, 3'b001, 4'h0, 3'b001, 3'b000, 4'd0, 4'd0, 4);
    // btn_0 release alongside card 3 settling, then press captures card 3
    add(0, 3'b000, 4'd3, 3'b001, 3'b000, 4'd0, 4'd0, 5);
    add(0, 3'b000, 4'd3, 3'b000, 3'b000, 4'd0, 4'd0, 1);
    add(0, 3'b000, 4'd3, 3'b000, 3'b000, 4'd3, 4'd0, 1);
    add(0, 3'b001, 4'd3, 3'b000, 3'b000, 4'd3, 4'd0, 3);
    add(0, 3'b001, 4'd5, 3'b000, 3'b000, 4'd3, 4'd0, 2);
    add(0, 3'b001, 4'd5, 3'b001, 3'b001, 4'd3, 4'd3, 1);
    add(0, 3'b001, 4'd5, 3'b001, 3'b000, 4'd3, 4'd3, 3);
    add(0, 3'b001, 4'd5, 3'b001, 3'b000, 4'd5, 4'd3, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].b, vecs[i].swr);
      tick();
      check($sformatf("vec%0d btn", i),    btns(),    {1'b0, vecs[i].eb});
      check($sformatf("vec%0d pulse", i),  pulses(),  {1'b0, vecs[i].ep});
      check($sformatf("vec%0d sw", i),     io.sw,     vecs[i].esw);
      check($sformatf("vec%0d sw_cap", i), io.sw_cap, vecs[i].ecap);
    end

    // switch bounce 2/6 every two cycles, final change to 6 sampled on tick 10
    for (int t = 0; t < 18; t++) begin
      drive(1'b0, 3'b000, (t < 12 && ((t / 2) % 2 == 0)) ? 4'd2 : 4'd6);
      tick();
      check($sformatf("bounce t%0d sw", t), io.sw, (t >= 16) ? 4'd6 : 4'd5);
      check($sformatf("bounce t%0d sw_cap", t), io.sw_cap, 4'd3);
    end

    // btn_2 held while rst pulses on the 3rd debounce cycle
    for (int t = 0; t < 12; t++) begin
      drive((t == 4) ? 1'b1 : 1'b0, 3'b100, 4'd6);
      tick();
      if (t == 4) begin
        check("midrst btn", btns(), 4'b0000);
        check("midrst pulse", pulses(), 4'b0000);
        check("midrst sw", io.sw, 4'd0);
        check("midrst sw_cap", io.sw_cap, 4'd0);
      end else begin
        check($sformatf("midrst t%0d btn", t), btns(), (t >= 10) ? 4'b0100 : 4'b0000);
        check($sformatf("midrst t%0d pulse", t), pulses(), (t == 10) ? 4'b0100 : 4'b0000);
        if (t >= 10)
          check($sformatf("midrst t%0d sw", t), io.sw, (t >= 11) ? 4'd6 : 4'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
